// File: rtl/wb_stage_reg.sv
// wb_stage_reg: two-entry elastic register between memory access and writeback.
// Main entry M drives every output straight from flops; skid entry S absorbs
// the one extra entry that arrives while the output is stalled, so in_ready is
// a pure function of local state.
//
// Handshake: an entry moves on a port only in a cycle where both valid and
// ready are high at the rising edge (accept = in_valid & in_ready,
// drain = out_valid & out_ready). A producer may not withdraw or change a
// presented entry based on ready; this stage holds out_* stable while
// out_valid=1 and out_ready=0.
module wb_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DATA_W-1:0] in_link,
  input  logic [DATA_W-1:0] in_hilo,
  input  logic [1:0]        in_wb_sel,
  input  logic [REG_AW-1:0] in_dst,
  input  logic              in_regwrite,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_mem,
  output logic [DATA_W-1:0] out_link,
  output logic [DATA_W-1:0] out_hilo,
  output logic [1:0]        out_wb_sel,
  output logic [REG_AW-1:0] out_dst,
  output logic              out_regwrite,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [DATA_W-1:0] link;
    logic [DATA_W-1:0] hilo;
    logic [1:0]        sel;
    logic [REG_AW-1:0] dst;
    logic              rw;
  } entry_t;

  state_t r_state;
  state_t w_state_nxt;
  entry_t r_m;
  entry_t r_s;
  entry_t w_in_entry;
  logic   r_out_valid;
  logic   r_in_ready;
  logic   w_accept;
  logic   w_drain;
  logic   w_load_m_in;
  logic   w_load_s;
  logic   w_move_s;

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_out_valid & out_ready;

  // Pack the incoming entry; register 0 is hard-wired, so never request a write to it.
  always_comb begin
    w_in_entry      = '0;
    w_in_entry.alu  = in_alu;
    w_in_entry.mem  = in_mem;
    w_in_entry.link = in_link;
    w_in_entry.hilo = in_hilo;
    w_in_entry.sel  = in_wb_sel;
    w_in_entry.dst  = in_dst;
    w_in_entry.rw   = in_regwrite & (in_dst != '0);
  end

  // Occupancy next-state and entry steering; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_load_m_in = 1'b0;
    w_load_s    = 1'b0;
    w_move_s    = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_load_m_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            w_load_m_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = ST_TWO;
            w_load_s    = 1'b1;
          end else if (w_drain) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_drain) begin
            w_state_nxt = ST_ONE;
            w_move_s    = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State plus registered handshake flags derived from the next state.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_in_ready  <= (w_state_nxt != ST_TWO);
    end
  end

  // Entry storage; emptied entries keep their contents.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_m <= '0;
      r_s <= '0;
    end else begin
      if (w_load_m_in) begin
        r_m <= w_in_entry;
      end else if (w_move_s) begin
        r_m <= r_s;
      end
      if (w_load_s) begin
        r_s <= w_in_entry;
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_alu      = r_m.alu;
  assign out_mem      = r_m.mem;
  assign out_link     = r_m.link;
  assign out_hilo     = r_m.hilo;
  assign out_wb_sel   = r_m.sel;
  assign out_dst      = r_m.dst;
  assign out_regwrite = r_m.rw & r_out_valid;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Bench for wb_stage_reg: directed scenarios plus a randomized run, all
// checked against a two-deep FIFO reference model.
module tb_wb_stage_reg;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          Clk;
  logic          Rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_alu, in_mem, in_link, in_hilo;
  logic [1:0]    in_wb_sel;
  logic [AW-1:0] in_dst;
  logic          in_regwrite;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_alu, out_mem, out_link, out_hilo;
  logic [1:0]    out_wb_sel;
  logic [AW-1:0] out_dst;
  logic          out_regwrite;
  logic [1:0]    dbg_state;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] mem;
    logic [DW-1:0] link;
    logic [DW-1:0] hilo;
    logic [1:0]    sel;
    logic [AW-1:0] dst;
    logic          rw;
  } ent_t;

  ent_t mq[$];
  int   n_chk;
  int   n_pass;

  wb_stage_reg #(.DATA_W(DW), .REG_AW(AW)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu(in_alu), .in_mem(in_mem), .in_link(in_link), .in_hilo(in_hilo),
    .in_wb_sel(in_wb_sel), .in_dst(in_dst), .in_regwrite(in_regwrite),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu(out_alu), .out_mem(out_mem), .out_link(out_link), .out_hilo(out_hilo),
    .out_wb_sel(out_wb_sel), .out_dst(out_dst), .out_regwrite(out_regwrite),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Driver tasks
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] m,
                      input logic [DW-1:0] l, input logic [DW-1:0] h,
                      input logic [1:0] s, input logic [AW-1:0] d, input logic rw);
    in_valid = 1'b1; in_alu = a; in_mem = m; in_link = l; in_hilo = h;
    in_wb_sel = s; in_dst = d; in_regwrite = rw;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // One clock: the model sees the same pre-edge inputs the DUT sees, then
  // outputs are sampled 1 ns after the edge.
  task automatic step();
    bit   acc, drn, fl;
    ent_t e;
    fl  = flush;
    acc = in_valid && (mq.size() < 2);
    drn = (mq.size() > 0) && out_ready;
    e.alu = in_alu; e.mem = in_mem; e.link = in_link; e.hilo = in_hilo;
    e.sel = in_wb_sel; e.dst = in_dst; e.rw = in_regwrite && (in_dst != 0);
    @(posedge Clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_alu = '0; in_mem = '0; in_link = '0; in_hilo = '0;
    in_wb_sel = '0; in_dst = '0; in_regwrite = 1'b0;
    #12;
    n_chk++;
    if ({out_valid, in_ready, out_regwrite} !== 3'b010) $display("FAIL reset_ctrl got %b exp 010", {out_valid, in_ready, out_regwrite});
    else n_pass++;
    n_chk++;
    if ({out_alu, out_mem, out_link, out_hilo, out_wb_sel, out_dst} !== '0) $display("FAIL reset_data got %h exp 0", {out_alu, out_mem, out_link, out_hilo, out_wb_sel, out_dst});
    else n_pass++;
    #1 Rst = 1'b1;
    step();
  endtask

  task automatic test_stream();
    logic [DW-1:0] vals [4];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(vals[i], 32'h0, 32'h0, 32'h0, 2'd0, 5'd1, 1'b1);
      step();
      n_chk++;
      if (!(out_valid === 1'b1 && out_alu === vals[i] && in_ready === 1'b1))
        $display("FAIL stream_%0d got v=%b alu=%h rdy=%b exp v=1 alu=%h rdy=1", i, out_valid, out_alu, in_ready, vals[i]);
      else n_pass++;
    end
    idle(); step();
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL stream_end got v=%b exp 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_alu [4];
    out_ready = 1'b0;
    send(32'hA, 0, 0, 0, 2'd0, 5'd2, 1'b1); step();
    send(32'hB, 0, 0, 0, 2'd0, 5'd3, 1'b1); step();
    n_chk++;
    if (!(in_ready === 1'b0 && out_valid === 1'b1 && out_alu === 32'hA))
      $display("FAIL bp_full got rdy=%b v=%b alu=%h exp rdy=0 v=1 alu=a", in_ready, out_valid, out_alu);
    else n_pass++;
    send(32'hC, 0, 0, 0, 2'd0, 5'd4, 1'b1); step();
    n_chk++;
    if (!(in_ready === 1'b0 && out_alu === 32'hA))
      $display("FAIL bp_hold got rdy=%b alu=%h exp rdy=0 alu=a", in_ready, out_alu);
    else n_pass++;
    out_ready = 1'b1;
    exp_alu[0] = 32'hB; exp_alu[1] = 32'hC;
    for (int i = 0; i < 2; i++) begin
      step();
      n_chk++;
      if (!(out_valid === 1'b1 && out_alu === exp_alu[i]))
        $display("FAIL bp_drain_%0d got v=%b alu=%h exp v=1 alu=%h", i, out_valid, out_alu, exp_alu[i]);
      else n_pass++;
      if (i == 0) begin
        n_chk++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready_back got %b exp 1", in_ready);
        else n_pass++;
      end else idle();
    end
    step();
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL bp_empty got v=%b exp 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_zero_guard();
    out_ready = 1'b1;
    send(32'h1, 0, 0, 0, 2'd0, 5'd0, 1'b1); step();
    n_chk++;
    if (!(out_regwrite === 1'b0 && out_dst === 5'd0 && out_valid === 1'b1))
      $display("FAIL zero_dst got rw=%b dst=%0d v=%b exp rw=0 dst=0 v=1", out_regwrite, out_dst, out_valid);
    else n_pass++;
    send(32'h2, 0, 0, 0, 2'd0, 5'd5, 1'b1); step();
    n_chk++;
    if (!(out_regwrite === 1'b1 && out_dst === 5'd5))
      $display("FAIL nonzero_dst got rw=%b dst=%0d exp rw=1 dst=5", out_regwrite, out_dst);
    else n_pass++;
    idle(); step();
    n_chk++;
    if (out_regwrite !== 1'b0) $display("FAIL rw_qualified got %b exp 0", out_regwrite);
    else n_pass++;
  endtask

  task automatic test_flush_two();
    out_ready = 1'b0;
    send(32'h51, 0, 0, 0, 2'd0, 5'd6, 1'b1); step();
    send(32'h52, 0, 0, 0, 2'd0, 5'd7, 1'b1); step();
    send(32'h53, 0, 0, 0, 2'd0, 5'd8, 1'b1);
    flush = 1'b1;
    step();
    n_chk++;
    if ({out_valid, out_regwrite, in_ready} !== 3'b001)
      $display("FAIL flush_state got v/rw/rdy=%b exp 001", {out_valid, out_regwrite, in_ready});
    else n_pass++;
    flush = 1'b0; idle(); out_ready = 1'b1;
    step(); step();
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL flush_no_ghost got v=%b alu=%h exp v=0", out_valid, out_alu);
    else n_pass++;
  endtask

  task automatic test_select();
    logic [DW-1:0] mux;
    out_ready = 1'b1;
    send(32'd1, 32'd2, 32'd3, 32'd4, 2'd2, 5'd9, 1'b1); step();
    case (out_wb_sel)
      2'd0: mux = out_alu;
      2'd1: mux = out_mem;
      2'd2: mux = out_link;
      default: mux = out_hilo;
    endcase
    n_chk++;
    if (!(out_alu === 32'd1 && out_mem === 32'd2 && out_link === 32'd3 && out_hilo === 32'd4 && out_wb_sel === 2'd2))
      $display("FAIL sel_fields got %0d/%0d/%0d/%0d sel=%0d exp 1/2/3/4 sel=2", out_alu, out_mem, out_link, out_hilo, out_wb_sel);
    else n_pass++;
    n_chk++;
    if (mux !== 32'd3) $display("FAIL sel_mux got %0d exp 3", mux);
    else n_pass++;
    idle(); step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(32'h61, 32'h62, 32'h63, 32'h64, 2'd3, 5'd10, 1'b1); step();
    send(32'h71, 32'h72, 32'h73, 32'h74, 2'd1, 5'd11, 1'b1); step();
    idle();
    #2 Rst = 1'b0;
    #1;
    mq.delete();
    n_chk++;
    if ({out_valid, in_ready, out_regwrite} !== 3'b010)
      $display("FAIL async_rst_ctrl got %b exp 010", {out_valid, in_ready, out_regwrite});
    else n_pass++;
    n_chk++;
    if ({out_alu, out_mem, out_link, out_hilo} !== '0)
      $display("FAIL async_rst_data got %h exp 0", {out_alu, out_mem, out_link, out_hilo});
    else n_pass++;
    @(negedge Clk);
    Rst = 1'b1;
    step();
  endtask

  task automatic test_random();
    logic [2:0]        exp_ctrl;
    logic [4*DW+AW+1:0] exp_pay;
    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_ctrl = {mq.size() > 0, mq.size() < 2, (mq.size() > 0) ? mq[0].rw : 1'b0};
      n_chk++;
      if ({out_valid, in_ready, out_regwrite} !== exp_ctrl)
        $display("FAIL rand_ctrl cyc=%0d got v/rdy/rw=%b exp %b", cyc, {out_valid, in_ready, out_regwrite}, exp_ctrl);
      else n_pass++;
      if (mq.size() > 0) begin
        exp_pay = {mq[0].alu, mq[0].mem, mq[0].link, mq[0].hilo, mq[0].sel, mq[0].dst};
        n_chk++;
        if ({out_alu, out_mem, out_link, out_hilo, out_wb_sel, out_dst} !== exp_pay)
          $display("FAIL rand_data cyc=%0d got %h exp %h", cyc, {out_alu, out_mem, out_link, out_hilo, out_wb_sel, out_dst}, exp_pay);
        else n_pass++;
      end
      if ($urandom_range(0, 2) != 0)
        send($urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)));
      else idle();
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      step();
    end
    flush = 1'b0; idle();
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_zero_guard();
    test_flush_two();
    test_select();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_stage_reg.md
# wb_stage_reg

Two-entry elastic pipeline register between memory access and writeback. It captures the four writeback candidates with their 2-bit select and destination control, and presents them registered to the 32-bit 4:1 writeback mux and the register file. A valid/ready handshake with a skid entry provides full throughput, and `in_ready` depends only on local state. A synchronous flush discards in-flight entries.

## Interface

Reset is asynchronous, active-low on `Rst`. One clock, `Clk`.

Parameters:
- `DATA_W`, 32, width of each writeback candidate.
- `REG_AW`, 5, register-file address width.

Ports:
- `Clk` in 1: single clock, rising edge.
- `Rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream entry valid.
- `in_ready` out 1: stage can accept an entry this cycle.
- `in_alu`, `in_mem`, `in_link`, `in_hilo` in DATA_W each: candidates a/b/c/d of the writeback mux.
- `in_wb_sel` in 2: select, where 0=alu, 1=mem, 2=link, 3=hilo.
- `in_dst` in REG_AW: destination register.
- `in_regwrite` in 1: write enable.
- `flush` in 1: synchronous discard of all held entries.
- `out_valid` out 1: output entry valid.
- `out_ready` in 1: downstream accepts the output entry.
- `out_alu`, `out_mem`, `out_link`, `out_hilo` out DATA_W: to mux inputs a/b/c/d.
- `out_wb_sel` out 2: to mux `sel`.
- `out_dst` out REG_AW: register-file write address.
- `out_regwrite` out 1: register-file write enable, already qualified by `out_valid`.

## Operation

Storage:
- main entry M drives all outputs directly from flops.
- skid entry S is a second full entry.

Handshakes:
- accept = `in_valid` & `in_ready`.
- drain = `out_valid` & `out_ready`.

State machine (encodes M/S occupancy):
- EMPTY: `out_valid`=0, `in_ready`=1.
  - accept → ONE; the input loads M.
- ONE: `out_valid`=1, `in_ready`=1.
  - accept & drain → ONE; the input loads M.
  - accept & !drain → TWO; the input loads S, M holds.
  - !accept & drain → EMPTY.
  - otherwise M holds.
- TWO: `out_valid`=1, `in_ready`=0.
  - drain → ONE; S moves to M.
  - otherwise both entries hold.
  - Input is never accepted in TWO, even if draining the same cycle.

Capture rules:
- On capture into M or S, the stored regwrite = `in_regwrite` & (`in_dst` != 0), because register 0 is never written.
- `out_regwrite` = stored regwrite & `out_valid`.
- Data, select and dst fields of an emptied entry keep their last value and are not cleared.

Flush:
- `flush`=1 at a rising edge forces state EMPTY.
- Any same-cycle accept is discarded.
- The same-cycle drain still counts as consumed downstream.
- Flush has priority over every other transition.

Reset:
- While `Rst`=0 the state is EMPTY.
- `out_valid`=0, `out_regwrite`=0, `in_ready`=1.
- All data, select and dst outputs = 0.

## Timing

- Latency: an entry accepted in cycle N appears on the outputs in cycle N+1 when the stage was EMPTY, or when it was ONE and drained in cycle N.
- Throughput: one entry per cycle while `out_ready`=1.
- `in_ready` and all outputs are registered. There is no combinational path from `out_ready`, `in_valid` or `flush` to any output.
- Entries leave in strict FIFO order. No entry is duplicated or dropped except by flush or reset.
- While `out_valid`=1 and `out_ready`=0, every output field is stable.
- Reset assertion mid-transfer clears the state immediately and asynchronously. Deassertion takes effect at the next rising `Clk`.

## Test plan

- Reset then stream: hold `out_ready`=1 and send 4 entries on consecutive cycles with `in_alu`=0x11,0x22,0x33,0x44 and `in_wb_sel`=0. Required: `out_valid` high cycles 1-4 with `out_alu` in the same order, and `in_ready` stays 1.
- Backpressure: with `out_ready`=0, send entries A (alu 0xA) and B (alu 0xB). Required: `in_ready`=0 after B, and a third entry C is not accepted. Raise `out_ready`: outputs A, then B, then C, with no loss.
- $zero guard: send `in_dst`=0 with `in_regwrite`=1, then `in_dst`=5 with `in_regwrite`=1. Required: `out_regwrite`=0 then 1, and `out_dst`=0 then 5.
- Flush in TWO: fill both entries with `out_ready`=0, then assert `flush` together with `in_valid`=1. Required: next cycle `out_valid`=0, `out_regwrite`=0, `in_ready`=1, and the flushed-cycle input never appears.
- Select passthrough: send `in_alu`=1, `in_mem`=2, `in_link`=3, `in_hilo`=4 with `in_wb_sel`=2. Required: the outputs carry the same 1/2/3/4 values and `out_wb_sel`=2, so the downstream mux yields 3.
- Async reset mid-stream: pull `Rst` low between clock edges while in TWO. Required: `out_valid`=0 and all data outputs = 0 immediately, without waiting for a clock edge, and `in_ready`=1.
